// File: rtl/fpu_pkg.sv
// Shared IEEE-754 format constants, special encodings and operand unpacking for the FPU.
package fpu_pkg;

  localparam int unsigned EXP_W_D = 11;
  localparam int unsigned MAN_W_D = 52;
  localparam int unsigned BIAS_D  = 1023;
  localparam int unsigned EXP_W_S = 8;
  localparam int unsigned MAN_W_S = 23;
  localparam int unsigned BIAS_S  = 127;

  localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] QNAN_S = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] PINF_D = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF_D = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] PINF_S = 64'h0000_0000_7F80_0000;
  localparam logic [63:0] NINF_S = 64'h0000_0000_FF80_0000;

  // Sized for binary64; binary32 operands are zero-extended into the low bits.
  typedef struct packed {
    logic        sign;
    logic [10:0] exp;   // effective exponent (1 for subnormals and zero)
    logic [52:0] mant;  // hidden bit plus fraction
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp_op_t;

  function automatic fp_op_t fp_unpack(input logic [63:0] op, input logic dbl);
    fp_op_t      u;
    logic [10:0] e;
    logic [51:0] f;
    logic        e_max;
    if (dbl) begin
      u.sign = op[63];
      e      = op[62:52];
      f      = op[51:0];
      e_max  = &e;
    end else begin
      u.sign = op[31];
      e      = {3'b000, op[30:23]};
      f      = {29'b0, op[22:0]};
      e_max  = &e[7:0];
    end
    u.is_zero = (e == 11'd0) && (f == 52'd0);
    u.is_inf  = e_max && (f == 52'd0);
    u.is_nan  = e_max && (f != 52'd0);
    u.exp     = (e == 11'd0) ? 11'd1 : e;
    u.mant    = dbl ? {(e != 11'd0), f} : {29'b0, (e != 11'd0), f[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input yields Width.
module fpu_lzc #(
  parameter  int unsigned Width = 56,
  localparam int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] value,
  output logic [CntW-1:0]  count
);

  // Scan upward so the highest set bit is the last to win.
  always_comb begin
    count = CntW'(Width);
    for (int i = 0; i < Width; i++) begin
      if (value[i]) count = CntW'(Width - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_add.sv
// IEEE-754 adder, binary32 or binary64 chosen at elaboration; one-cycle registered result.
module fpu_add
  import fpu_pkg::*;
#(
  parameter bit double = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);

  localparam int unsigned EW   = double ? EXP_W_D : EXP_W_S;
  localparam int unsigned MW   = double ? MAN_W_D : MAN_W_S;
  localparam int unsigned Bias = double ? BIAS_D : BIAS_S;
  localparam int unsigned AW   = MW + 4;  // hidden, fraction, guard, round, sticky
  localparam int unsigned LzW  = $clog2(AW + 1);
  localparam logic [EW:0] ExpMax = (EW + 1)'(2 * Bias);
  localparam logic [63:0] QNan   = double ? QNAN_D : QNAN_S;
  localparam logic [63:0] InfPos = double ? PINF_D : PINF_S;
  localparam logic [63:0] InfNeg = double ? NINF_D : NINF_S;

  fp_op_t        ua, ub, ux, uy;
  logic [63:0]   xraw;
  logic          a_ge;
  logic [EW-1:0] ex, ey, diff;
  logic [MW:0]   mx, my;
  logic [AW-1:0] xm_ext, ym_ext, lost_mask, ym_sh, ym_al;
  logic          sticky;
  logic [AW:0]   sum;
  logic [AW-1:0] sum_lo;
  logic [LzW-1:0] lz;
  logic [EW-1:0] lim, shamt;
  logic [AW-1:0] norm;
  logic [EW:0]   exp_n, exp_f;
  logic          round_up;
  logic [MW+1:0] mant_r;
  logic [MW-1:0] frac;
  logic [63:0]   packed_res, res_d, result_q;

  // Unpack, order by magnitude, align the smaller operand and add/subtract.
  always_comb begin
    ua     = fp_unpack(a, double);
    ub     = fp_unpack(b, double);
    a_ge   = {ua.exp[EW-1:0], ua.mant[MW:0]} >= {ub.exp[EW-1:0], ub.mant[MW:0]};
    ux     = a_ge ? ua : ub;
    uy     = a_ge ? ub : ua;
    xraw   = a_ge ? a : b;
    ex     = ux.exp[EW-1:0];
    ey     = uy.exp[EW-1:0];
    mx     = ux.mant[MW:0];
    my     = uy.mant[MW:0];
    diff   = ex - ey;
    xm_ext = {mx, 3'b000};
    ym_ext = {my, 3'b000};
    lost_mask = ~({AW{1'b1}} << diff);
    sticky    = |(ym_ext & lost_mask);
    ym_sh     = ym_ext >> diff;
    if (32'(diff) >= MW + 3) begin
      ym_al = {{(AW - 1){1'b0}}, |my};
    end else begin
      ym_al = {ym_sh[AW-1:1], ym_sh[0] | sticky};
    end
    if (ux.sign ^ uy.sign) begin
      sum = {1'b0, xm_ext} - {1'b0, ym_al};
    end else begin
      sum = {1'b0, xm_ext} + {1'b0, ym_al};
    end
  end

  assign sum_lo = sum[AW-1:0];

  fpu_lzc #(
    .Width (AW)
  ) u_lzc (
    .value (sum_lo),
    .count (lz)
  );

  // Normalize, then round to nearest even.
  always_comb begin
    lim   = ex - EW'(1);
    shamt = (EW'(lz) > lim) ? lim : EW'(lz);
    if (sum[AW]) begin
      norm  = {sum[AW:2], sum[1] | sum[0]};
      exp_n = {1'b0, ex} + (EW + 1)'(1);
    end else begin
      // Limiting the shift keeps the exponent at 1, producing a subnormal.
      norm  = sum_lo << shamt;
      exp_n = {1'b0, ex - shamt};
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[AW-1:3]} + (MW + 2)'(round_up);
    exp_f    = '0;
    frac     = mant_r[MW-1:0];
    if (mant_r[MW+1]) begin
      exp_f = exp_n + (EW + 1)'(1);
      frac  = mant_r[MW:1];
    end else if (mant_r[MW]) begin
      exp_f = exp_n;
    end
    packed_res                 = '0;
    packed_res[EW+MW]          = ux.sign;
    packed_res[EW+MW-1:MW]     = exp_f[EW-1:0];
    packed_res[MW-1:0]         = frac;
  end

  always_comb begin
    res_d = packed_res;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
      res_d = QNan;
    end else if (ux.is_inf) begin
      res_d = ux.sign ? InfNeg : InfPos;
    end else if (ux.is_zero) begin
      res_d           = '0;
      res_d[EW+MW]    = ua.sign & ub.sign;
    end else if (uy.is_zero) begin
      res_d = double ? xraw : {32'b0, xraw[31:0]};
    end else if (sum == '0) begin
      res_d = '0;
    end else if (exp_f > ExpMax) begin
      res_d = ux.sign ? InfNeg : InfPos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= res_d;
    end
  end

  assign result = result_q;

  // Format-dependent slices leave some operand and struct bits unread.
  logic unused_ok;
  assign unused_ok = ^{a, b, ua, ub, ux, uy, xraw};

endmodule

// File: tb/tb_fpu_add.sv
// Table-driven scoreboard bench for fpu_add in both binary64 and binary32 builds.
module tb_fpu_add;

  logic        clk;
  logic        rst_n;
  logic [63:0] a_d, b_d, result_d;
  logic [63:0] a_s, b_s, result_s;

  fpu_add #(.double(1'b1)) dut_d (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a_d),
    .b      (b_d),
    .result (result_d)
  );

  fpu_add #(.double(1'b0)) dut_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a_s),
    .b      (b_s),
    .result (result_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        dbl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
  } vec_t;

  typedef struct {
    string       name;
    logic        dbl;
    logic [63:0] res;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass;
  int   n_total;

  task automatic add_vec(input string name, input logic dbl, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] vr);
    vec_t v;
    v.name = name;
    v.dbl  = dbl;
    v.a    = va;
    v.b    = vb;
    v.res  = vr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue, expected a pending result");
    end else begin
      e = sb.pop_front();
      check(e.name, e.dbl ? result_d : result_s, e.res);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    if (v.dbl) begin
      a_d = v.a;  b_d = v.b;  a_s = '0;  b_s = '0;
    end else begin
      a_s = v.a;  b_s = v.b;  a_d = '0;  b_d = '0;
    end
    e.name = v.name;
    e.dbl  = v.dbl;
    e.res  = v.res;
    sb.push_back(e);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    add_vec("d_x_plus_zero", 1'b1, 64'h3FF0000000000000, 64'h0, 64'h3FF0000000000000);
    add_vec("d_2_plus_3", 1'b1, 64'h4000000000000000, 64'h4008000000000000, 64'h4014000000000000);
    add_vec("d_m1_plus_half", 1'b1, 64'hBFF0000000000000, 64'h3FE0000000000000, 64'hBFE0000000000000);
    add_vec("d_cancel", 1'b1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'h0);
    add_vec("d_tie_even_down", 1'b1, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000);
    add_vec("d_tie_even_up", 1'b1, 64'h3FF0000000000001, 64'h3CA0000000000000, 64'h3FF0000000000002);
    add_vec("d_one_minus_ulp", 1'b1, 64'h3FF0000000000000, 64'hBCA0000000000000, 64'h3FEFFFFFFFFFFFFF);
    add_vec("d_inf_minus_inf", 1'b1, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000);
    add_vec("d_overflow", 1'b1, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000);
    add_vec("d_subnormals", 1'b1, 64'h0008000000000000, 64'h0008000000000000, 64'h0010000000000000);
    add_vec("d_sub_to_normal", 1'b1, 64'h000FFFFFFFFFFFFF, 64'h0000000000000001, 64'h0010000000000000);
    add_vec("d_snan", 1'b1, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000);
    add_vec("d_ninf_plus_fin", 1'b1, 64'hFFF0000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000);
    add_vec("d_nz_plus_nz", 1'b1, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000);
    add_vec("d_pz_plus_nz", 1'b1, 64'h0000000000000000, 64'h8000000000000000, 64'h0);
    add_vec("d_subn_plus_nz", 1'b1, 64'h0000000000000001, 64'h8000000000000000, 64'h0000000000000001);
    add_vec("d_m3_plus_2", 1'b1, 64'hC008000000000000, 64'h4000000000000000, 64'hBFF0000000000000);
    add_vec("s_1_plus_1", 1'b0, 64'h3F800000, 64'h3F800000, 64'h0000000040000000);
    add_vec("s_inf_minus_inf", 1'b0, 64'h7F800000, 64'hFF800000, 64'h000000007FC00000);
    add_vec("s_cancel", 1'b0, 64'h3F800000, 64'hBF800000, 64'h0);
    add_vec("s_upper_ignored", 1'b0, 64'hFFFFFFFF3F800000, 64'h1234567840000000, 64'h0000000040400000);
    add_vec("s_overflow", 1'b0, 64'h7F7FFFFF, 64'h7F7FFFFF, 64'h000000007F800000);

    rst_n = 1'b0;
    a_d = '0;  b_d = '0;  a_s = '0;  b_s = '0;
    #1;
    check("reset_d", result_d, 64'h0);
    check("reset_s", result_s, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: each negedge checks the previous cycle's operands.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check_front();
      drive(vecs[i]);
    end
    @(negedge clk);
    check_front();

    // Asynchronous reset in the middle of a stream.
    a_s = 64'h3F800000;  b_s = 64'h3F800000;
    @(posedge clk);
    #1;
    check("s_pre_reset", result_s, 64'h0000000040000000);
    a_s = 64'h40000000;  b_s = 64'h40000000;
    #2;
    rst_n = 1'b0;
    #1;
    check("s_async_reset", result_s, 64'h0);
    check("d_async_reset", result_d, 64'h0);
    @(posedge clk);
    #1;
    check("s_reset_held", result_s, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_after_reset", result_s, 64'h0000000040800000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpu_add.md
Name: fpu_add

Overview:
- IEEE-754 binary floating-point adder for single or double precision, selected at elaboration.
- Sits in the FPU datapath as the add/subtract primitive. Subtract is done by the caller flipping the sign of b.
- Inputs are combinational. The result is registered once, so latency is one clock.
- Always enabled: no handshake. A new operand pair may be applied every cycle.

Parameters:
- double, 0, precision select. 0 = binary32 on bits [31:0]; 1 = binary64 on bits [63:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  64  operand A. When double=0, only [31:0] is used and [63:32] is ignored.
- b  input  64  operand B, same packing as a.
- result  output  64  registered sum a+b. When double=0, [63:32] is driven 0.

Behaviour:
- Format constants:
  - double=1: EXP_W=11, MAN_W=52, BIAS=1023.
  - double=0: EXP_W=8, MAN_W=23, BIAS=127.
- Reset: result=0 immediately when rst_n is low, held until the first rising clk edge after rst_n goes high.
- Reset mid-operation discards any in-flight result. No other state exists.
- Latency: result at posedge N reflects a,b sampled at posedge N. Throughput is 1 per cycle.
- Datapath order:
  - Unpack: hidden bit is 1 for normals and 0 for subnormals; a subnormal's effective exponent is 1.
  - Swap so the larger magnitude is operand X (compare exponent, then mantissa).
  - Align Y right by the exponent difference, keeping guard, round and sticky bits. A shift of MAN_W+3 or more leaves only sticky.
  - Add or subtract mantissas according to the XOR of the signs.
  - Normalize: on carry-out, shift right 1 and increment the exponent. Otherwise shift left by the leading-zero count, limited so the exponent does not go below 1 (gradual underflow produces a subnormal).
  - Round to nearest, ties to even. Mantissa overflow from rounding increments the exponent.
- Special cases:
  - Either operand NaN → canonical quiet NaN: 0x7FF8000000000000 for double, 0x7FC00000 for single.
  - +inf + -inf → canonical quiet NaN.
  - inf + finite → that inf. inf + same-sign inf → inf.
  - Exact cancellation (x + -x) → +0.
  - +0 + +0 → +0. -0 + -0 → -0. +0 + -0 → +0.
  - x + ±0 → x, bit-exact, including subnormal x.
- Overflow after rounding (exponent reaches all-ones) → correctly signed infinity.
- Sign of a nonzero result is the sign of the larger-magnitude operand.
- No exception flags are produced.

Decomposition:
- Package fpu_pkg holds:
  - per-precision constants EXP_W, MAN_W, BIAS;
  - canonical qNaN constants for binary32 and binary64;
  - ±inf encodings;
  - an unpacked-operand struct {sign, exp, mant, is_zero, is_inf, is_nan}.
- One sub-module, fpu_lzc: parameterized leading-zero counter over the normalization-width mantissa, used in the left-normalize step.
- Rounding stays inline in fpu_add.

Test Plan:
- double=1, a=0x3FF0000000000000, b=0 → result 0x3FF0000000000000 one clock later.
- double=1, a=0x4000000000000000, b=0x4008000000000000 (2+3) → 0x4014000000000000.
- double=1, a=0xBFF0000000000000, b=0x3FE0000000000000 (-1+0.5) → 0xBFE0000000000000. Also a=0xBFF0000000000000, b=0x3FF0000000000000 → 0x0000000000000000.
- double=1, rounding tie: a=0x3FF0000000000000, b=0x3CA0000000000000 (1+2^-53) → 0x3FF0000000000000.
- double=1, specials:
  - a=0x7FF0000000000000, b=0xFFF0000000000000 → 0x7FF8000000000000.
  - a=b=0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000.
  - a=b=0x0008000000000000 (subnormals) → 0x0010000000000000.
- double=0, a=b=0x3F800000 → result 0x0000000040000000. Then assert rst_n=0 mid-stream → result 0 immediately, with no clock edge required.
